// File: rtl/dds_multi.sv
// Multi-channel quarter-wave DDS: CH phase accumulators share one external quarter-sine SRAM.
// Optional macro DDS_TWOS_NEG_EN selects two's-complement negation (default: one's complement).
module dds_multi #(
    parameter int CH      = 2,
    parameter int PHASE_W = 18,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [CH*PHASE_W-1:0]  ftw,
    input  logic [CH*PHASE_W-1:0]  poff,
    output logic                   busy,
    output logic                   valid,
    output logic [CH*DATA_W-1:0]   sin,
    output logic [CH*DATA_W-1:0]   cos,
    output logic [PHASE_W-3:0]     addr,
    input  logic [DATA_W-1:0]      data
);

    localparam int LAST_ISSUE = 2*CH - 1;
    localparam int DRAIN_END  = 2*CH + RD_LAT - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    state_t             state;
    logic               go_q;
    int                 cnt;
    logic [PHASE_W-1:0] acc    [CH];
    logic [PHASE_W-1:0] ph     [CH];
    logic [DATA_W-1:0]  sh_sin [CH];
    logic [DATA_W-1:0]  sh_cos [CH];
    logic [PHASE_W-1:0] ph0_now;

    // Slot 0 is addressed on the trigger edge itself, before ph[0] is registered.
    assign ph0_now = acc[0] + poff[PHASE_W-1:0];

    function automatic logic [PHASE_W-3:0] tbl_addr(input logic [PHASE_W-1:0] p, input logic is_cos);
        logic [PHASE_W-3:0] m;
        m = p[PHASE_W-3:0];
        return (p[PHASE_W-2] ^ is_cos) ? ~m : m;
    endfunction

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] d, input logic neg);
`ifdef DDS_TWOS_NEG_EN
        return neg ? (~d + 1'b1) : d;
`else
        return neg ? ~d : d;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            go_q  <= 1'b0;
            cnt   <= 0;
            busy  <= 1'b0;
            valid <= 1'b0;
            addr  <= '0;
            sin   <= '0;
            cos   <= '0;
            for (int c = 0; c < CH; c++) begin
                acc[c]    <= '0;
                ph[c]     <= '0;
                sh_sin[c] <= '0;
                sh_cos[c] <= '0;
            end
        end else begin
            go_q  <= go;
            valid <= 1'b0;

            // cnt holds the number of the current edge counted from the trigger edge
            if (state != IDLE) begin
                cnt <= cnt + 1;
                for (int c = 0; c < CH; c++) begin
                    if (cnt == 2*c + RD_LAT)
                        sh_sin[c] <= fold(data, ph[c][PHASE_W-1]);
                    if (cnt == 2*c + 1 + RD_LAT)
                        sh_cos[c] <= fold(data, ph[c][PHASE_W-1] ^ ph[c][PHASE_W-2]);
                end
            end

            case (state)
                IDLE: begin
                    if (go && !go_q) begin
                        for (int c = 0; c < CH; c++)
                            ph[c] <= acc[c] + poff[c*PHASE_W +: PHASE_W];
                        addr  <= tbl_addr(ph0_now, 1'b0);
                        cnt   <= 1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    for (int c = 0; c < CH; c++) begin
                        if (cnt == 2*c)
                            addr <= tbl_addr(ph[c], 1'b0);
                        if (cnt == 2*c + 1)
                            addr <= tbl_addr(ph[c], 1'b1);
                    end
                    if (cnt == LAST_ISSUE)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (cnt == DRAIN_END)
                        state <= COMMIT;
                end
                COMMIT: begin
                    for (int c = 0; c < CH; c++) begin
                        sin[c*DATA_W +: DATA_W] <= sh_sin[c];
                        cos[c*DATA_W +: DATA_W] <= sh_cos[c];
                        acc[c] <= acc[c] + ftw[c*PHASE_W +: PHASE_W];
                    end
                    addr  <= '0;
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_multi.sv
// Directed self-checking bench for dds_multi: a CH=2/RD_LAT=1 instance and a CH=3/RD_LAT=3 instance.
module tb_dds_multi;

`ifdef DDS_TWOS_NEG_EN
    localparam bit TWOS = 1'b1;
`else
    localparam bit TWOS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, go, go3;
    logic [35:0] ftw, poff;
    logic        busy, valid;
    logic [31:0] sin, cos;
    logic [15:0] addr, data;

    logic [53:0] ftw3, poff3;
    logic        busy3, valid3;
    logic [47:0] sin3, cos3;
    logic [15:0] addr3, data3, d1, d2;

    int checks = 0;
    int errors = 0;

    // SRAM models whose contents equal the address, with the instance's read latency.
    assign data = addr;
    always @(posedge clk) begin
        d1 <= addr3;
        d2 <= d1;
    end
    assign data3 = d2;

    dds_multi #(.CH(2), .PHASE_W(18), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .ftw(ftw), .poff(poff),
        .busy(busy), .valid(valid), .sin(sin), .cos(cos), .addr(addr), .data(data)
    );

    dds_multi #(.CH(3), .PHASE_W(18), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .go(go3), .ftw(ftw3), .poff(poff3),
        .busy(busy3), .valid(valid3), .sin(sin3), .cos(cos3), .addr(addr3), .data(data3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // Trigger one sweep, report the address on the trigger edge and the edge count until valid.
    task automatic applyStimulus(input bit sel, output logic [15:0] addrE, output int lat);
        lat = -1;
        if (sel) go3 = 1'b1;
        else     go  = 1'b1;
        waitEdge();
        addrE = sel ? addr3 : addr;
        go  = 1'b0;
        go3 = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            waitEdge();
            if (sel ? valid3 : valid) lat = k;
        end
    endtask

    logic [15:0] a;
    int          lat, n;
    logic [15:0] exp3 [6];

    initial begin
        rst_n = 1'b0; go = 1'b0; go3 = 1'b0;
        ftw = '0; poff = '0; ftw3 = '0; poff3 = '0;
        exp3 = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        repeat (2) waitEdge();
        checkOutput("rst busy", busy, 0);
        checkOutput("rst valid", valid, 0);
        checkOutput("rst addr", addr, 0);
        checkOutput("rst sin", sin, 0);
        checkOutput("rst cos", cos, 0);
        rst_n = 1'b1;
        waitEdge();

        // Basic sweep: address sequence and commit timing
        poff = {18'h10000, 18'h00000};
        go = 1'b1;
        waitEdge();
        go = 1'b0;
        checkOutput("t1 addr E", addr, 16'h0000);
        checkOutput("t1 busy E", busy, 1);
        waitEdge();
        checkOutput("t1 addr E1", addr, 16'hFFFF);
        waitEdge();
        checkOutput("t1 addr E2", addr, 16'hFFFF);
        waitEdge();
        checkOutput("t1 addr E3", addr, 16'h0000);
        checkOutput("t1 valid E3", valid, 0);
        waitEdge();
        checkOutput("t1 valid E4", valid, 0);
        checkOutput("t1 busy E4", busy, 1);
        waitEdge();
        checkOutput("t1 valid E5", valid, 1);
        checkOutput("t1 busy E5", busy, 0);
        checkOutput("t1 sin", sin, {16'hFFFF, 16'h0000});
        checkOutput("t1 cos", cos, {(TWOS ? 16'h0000 : 16'hFFFF), 16'hFFFF});
        waitEdge();
        checkOutput("t1 valid pulse", valid, 0);

        // Third quadrant negation
        poff = {18'h10000, 18'h20000};
        applyStimulus(1'b0, a, lat);
        checkOutput("t2 lat", lat, 5);
        checkOutput("t2 sin0", sin[15:0], TWOS ? 16'h0000 : 16'hFFFF);
        checkOutput("t2 cos0", cos[15:0], TWOS ? 16'h0001 : 16'h0000);

        // Accumulation across sweeps
        ftw  = {18'h0, 18'h00100};
        poff = '0;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, a, lat);
            checkOutput("t3 snap addr", a, 16'(s * 256));
            checkOutput("t3 sin0", sin[15:0], 16'(s * 256));
        end

        // Accumulator wrap with ftw = -1
        rst_n = 1'b0;
        waitEdge();
        rst_n = 1'b1;
        ftw = {18'h0, 18'h3FFFF};
        applyStimulus(1'b0, a, lat);
        checkOutput("t3w snap0", a, 16'h0000);
        checkOutput("t3w sin0 a", sin[15:0], 16'h0000);
        applyStimulus(1'b0, a, lat);
        checkOutput("t3w snap1", a, 16'h0000);
        checkOutput("t3w sin0 b", sin[15:0], TWOS ? 16'h0000 : 16'hFFFF);
        checkOutput("t3w cos0 b", cos[15:0], 16'hFFFF);
        applyStimulus(1'b0, a, lat);
        checkOutput("t3w snap2", a, 16'h0001);
        checkOutput("t3w sin0 c", sin[15:0], TWOS ? 16'hFFFF : 16'hFFFE);
        checkOutput("t3w cos0 c", cos[15:0], 16'hFFFE);

        // Retrigger during a sweep is ignored
        ftw = '0;
        go = 1'b1;
        waitEdge();
        go = 1'b0;
        waitEdge();
        go = 1'b1;
        waitEdge();
        go = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            waitEdge();
            if (valid) n++;
        end
        checkOutput("t4 one valid", n, 1);

        // Held-high go starts only one sweep
        go = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            waitEdge();
            if (valid) n++;
        end
        checkOutput("t4 held valid", n, 1);
        checkOutput("t4 held busy", busy, 0);
        go = 1'b0;
        waitEdge();
        applyStimulus(1'b0, a, lat);
        checkOutput("t4 rearm lat", lat, 5);

        // Reset in the middle of a sweep
        go = 1'b1;
        waitEdge();
        go = 1'b0;
        waitEdge();
        waitEdge();
        rst_n = 1'b0;
        #1;
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 valid", valid, 0);
        checkOutput("t5 addr", addr, 0);
        checkOutput("t5 sin", sin, 0);
        checkOutput("t5 cos", cos, 0);
        waitEdge();
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            waitEdge();
            if (valid) n++;
        end
        checkOutput("t5 no valid", n, 0);
        applyStimulus(1'b0, a, lat);
        checkOutput("t5 acc cleared addr", a, 16'h0000);
        checkOutput("t5 acc cleared sin0", sin[15:0], 16'h0000);

        // Three channels, read latency 3
        poff3 = {18'h08000, 18'h10000, 18'h00000};
        go3 = 1'b1;
        waitEdge();
        go3 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) checkOutput($sformatf("t6 addr E%0d", k), addr3, exp3[k]);
            checkOutput($sformatf("t6 busy E%0d", k), busy3, 1);
            checkOutput($sformatf("t6 valid E%0d", k), valid3, 0);
            waitEdge();
        end
        checkOutput("t6 valid E9", valid3, 1);
        checkOutput("t6 busy E9", busy3, 0);
        checkOutput("t6 sin", sin3, {16'h8000, 16'hFFFF, 16'h0000});
        checkOutput("t6 cos", cos3, {16'h7FFF, (TWOS ? 16'h0000 : 16'hFFFF), 16'hFFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
